// File: rtl/vx_alu_sad8.sv
// -----------------------------------------------------------------------------
// vx_alu_sad8
//
// Per-lane sum of absolute byte differences with accumulate, for a SIMD
// execute unit:
//
//   result[lane] = rs3 + sum_{k=0..3} |rs1.byte[k] - rs2.byte[k]|   (mod 2^32)
//
// Bytes are unsigned (0..255) or two's-complement (-128..127), chosen per
// request. Inactive lanes (tmask bit 0) return zero. The tag and tmask are
// opaque sideband and travel with the data unchanged.
//
// Two-stage valid/ready pipeline:
//   S1 : four 9-bit absolute differences per lane, rs3, tmask, tag
//   S2 : final per-lane sum (this is the output register)
// A request presented in the cycle that starts at edge N is captured by S1 at
// edge N+1 and appears on the outputs after edge N+2. One request per cycle is
// sustained while result_ready_i stays high.
//
// Ports
//   clk_i                 clock, rising edge
//   reset_i               synchronous reset, active low
//   execute_valid_i       request valid
//   execute_ready_o       request accepted when valid and ready are both 1
//   execute_op_signed_i   0: unsigned bytes, 1: signed bytes
//   execute_tmask_i       active-lane mask            [NUM_LANES]
//   execute_tag_i         sideband tag                [TAG_WIDTH]
//   execute_rs1_data_i    operand A, lane i at [32i+31:32i]
//   execute_rs2_data_i    operand B, lane i at [32i+31:32i]
//   execute_rs3_data_i    accumulator, lane i at [32i+31:32i]
//   result_valid_o        result valid
//   result_ready_i        result consumed when valid and ready are both 1
//   result_tmask_o        echoed mask
//   result_tag_o          echoed tag
//   result_data_o         per-lane result
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vx_alu_sad8 #(
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 44
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  input  logic                   execute_valid_i,
  output logic                   execute_ready_o,
  input  logic                   execute_op_signed_i,
  input  logic [NUM_LANES-1:0]   execute_tmask_i,
  input  logic [TAG_WIDTH-1:0]   execute_tag_i,
  input  logic [NUM_LANES*32-1:0] execute_rs1_data_i,
  input  logic [NUM_LANES*32-1:0] execute_rs2_data_i,
  input  logic [NUM_LANES*32-1:0] execute_rs3_data_i,

  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [NUM_LANES-1:0]   result_tmask_o,
  output logic [TAG_WIDTH-1:0]   result_tag_o,
  output logic [NUM_LANES*32-1:0] result_data_o
);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // |a - b| for one byte pair. Both bytes are widened to 9 bits (sign- or
  // zero-extended), compared as signed 9-bit values, and the smaller is
  // subtracted from the larger. The true magnitude is at most 255, so the
  // 9-bit subtraction never loses information.
  function automatic logic [8:0] abs_diff(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic       is_signed);
    logic [8:0] a9;
    logic [8:0] b9;
    a9 = {is_signed & a[7], a};
    b9 = {is_signed & b[7], b};
    if ($signed(a9) >= $signed(b9)) begin
      return a9 - b9;
    end else begin
      return b9 - a9;
    end
  endfunction

  // Four terms of at most 255 each: 10 bits hold the worst case of 1020.
  function automatic logic [9:0] lane_sum(input logic [3:0][8:0] ad);
    return {1'b0, ad[0]} + {1'b0, ad[1]} + {1'b0, ad[2]} + {1'b0, ad[3]};
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic result_valid_q, result_valid_d;
  logic s2_load;
  logic s1_load;

  // S2 takes a new value whenever its current content is empty or leaving.
  // S1 may advance whenever it is empty or S2 is about to absorb it, which
  // lets both stages shift together with no bubble on a simultaneous
  // consume and accept.
  always_comb begin
    s2_load         = ~result_valid_q | result_ready_i;
    s1_load         = ~s1_valid_q | s2_load;
    execute_ready_o = s1_load;
    s1_valid_d      = s1_load ? execute_valid_i : s1_valid_q;
    result_valid_d  = s2_load ? s1_valid_q      : result_valid_q;
  end

  // Only the valid bits carry meaning after reset; clearing them discards
  // everything in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      s1_valid_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values of the others; blocking here would let
      // S2 see the value S1 is loading in the same edge.
      s1_valid_q     <= s1_valid_d;
      result_valid_q <= result_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: absolute differences
  // ---------------------------------------------------------------------------
  logic [NUM_LANES-1:0][3:0][8:0] s1_ad_q,  s1_ad_d;
  logic [NUM_LANES-1:0][31:0]     s1_rs3_q;
  logic [NUM_LANES-1:0]           s1_tmask_q;
  logic [TAG_WIDTH-1:0]           s1_tag_q;

  always_comb begin
    // NOTE: every combinational output gets a default before the loops so no
    // path leaves it unassigned, which would otherwise infer a latch.
    s1_ad_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int k = 0; k < 4; k++) begin
        s1_ad_d[l][k] = abs_diff(execute_rs1_data_i[32*l + 8*k +: 8],
                                 execute_rs2_data_i[32*l + 8*k +: 8],
                                 execute_op_signed_i);
      end
    end
  end

  // NOTE: datapath registers carry no reset; their contents are ignored
  // until the matching valid bit is set, and leaving them unreset keeps the
  // reset net off the wide payload.
  always_ff @(posedge clk_i) begin
    if (s1_load && execute_valid_i) begin
      s1_ad_q    <= s1_ad_d;
      s1_rs3_q   <= execute_rs3_data_i;
      s1_tmask_q <= execute_tmask_i;
      s1_tag_q   <= execute_tag_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate and mask
  // ---------------------------------------------------------------------------
  logic [NUM_LANES*32-1:0] result_data_q,  result_data_d;
  logic [NUM_LANES-1:0]    result_tmask_q;
  logic [TAG_WIDTH-1:0]    result_tag_q;

  always_comb begin
    result_data_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      // The 10-bit sum is zero-extended; the 32-bit add wraps naturally.
      if (s1_tmask_q[l]) begin
        result_data_d[32*l +: 32] = s1_rs3_q[l] + {22'd0, lane_sum(s1_ad_q[l])};
      end
    end
  end

  // The output register only changes when S2 loads, so data, tag and mask
  // hold steady for as long as the consumer applies backpressure.
  always_ff @(posedge clk_i) begin
    if (s2_load && s1_valid_q) begin
      result_data_q  <= result_data_d;
      result_tmask_q <= s1_tmask_q;
      result_tag_q   <= s1_tag_q;
    end
  end

  assign result_valid_o = result_valid_q;
  assign result_data_o  = result_data_q;
  assign result_tmask_o = result_tmask_q;
  assign result_tag_o   = result_tag_q;

endmodule

// File: tb/tb_vx_alu_sad8.sv
// -----------------------------------------------------------------------------
// tb_vx_alu_sad8
//
// Self-checking bench for vx_alu_sad8. Directed vectors come from a table of
// {operands, expected lanes}; random traffic is scored against a small
// integer reference model. Every accepted request pushes its expected result
// onto a queue; a monitor pops and compares whenever the DUT hands a result
// over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vx_alu_sad8;

  localparam int NL = 4;
  localparam int TW = 44;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            execute_valid_i;
  logic            execute_ready_o;
  logic            execute_op_signed_i;
  logic [NL-1:0]   execute_tmask_i;
  logic [TW-1:0]   execute_tag_i;
  logic [NL*32-1:0] execute_rs1_data_i;
  logic [NL*32-1:0] execute_rs2_data_i;
  logic [NL*32-1:0] execute_rs3_data_i;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [NL-1:0]   result_tmask_o;
  logic [TW-1:0]   result_tag_o;
  logic [NL*32-1:0] result_data_o;

  always #5 clk = ~clk;

  vx_alu_sad8 #(.NUM_LANES(NL), .TAG_WIDTH(TW)) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .execute_valid_i     (execute_valid_i),
    .execute_ready_o     (execute_ready_o),
    .execute_op_signed_i (execute_op_signed_i),
    .execute_tmask_i     (execute_tmask_i),
    .execute_tag_i       (execute_tag_i),
    .execute_rs1_data_i  (execute_rs1_data_i),
    .execute_rs2_data_i  (execute_rs2_data_i),
    .execute_rs3_data_i  (execute_rs3_data_i),
    .result_valid_o      (result_valid_o),
    .result_ready_i      (result_ready_i),
    .result_tmask_o      (result_tmask_o),
    .result_tag_o        (result_tag_o),
    .result_data_o       (result_data_o)
  );

  typedef struct packed {
    logic             sgn;
    logic [NL-1:0]    tmask;
    logic [TW-1:0]    tag;
    logic [NL*32-1:0] rs1;
    logic [NL*32-1:0] rs2;
    logic [NL*32-1:0] rs3;
  } req_t;

  typedef struct packed {
    logic [TW-1:0]    tag;
    logic [NL-1:0]    tmask;
    logic [NL*32-1:0] data;
  } exp_t;

  // One table row: operands replicated to every lane, expected lanes 3..0.
  typedef struct packed {
    logic        sgn;
    logic [3:0]  tmask;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic [127:0] exp;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  exp_t sb_q [$];
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   out_cnt = 0;
  logic rand_rdy = 1'b0;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_vec(input string name, input logic [127:0] act,
                           input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (plain integer arithmetic)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] model_lane(input logic sgn, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
    int sum;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ab;
      logic [7:0] bb;
      int ai;
      int bi;
      ab = a[8*k +: 8];
      bb = b[8*k +: 8];
      if (sgn) begin
        ai = int'($signed(ab));
        bi = int'($signed(bb));
      end else begin
        ai = int'(ab);
        bi = int'(bb);
      end
      if (ai > bi) sum += ai - bi;
      else         sum += bi - ai;
    end
    return c + 32'(sum);
  endfunction

  function automatic exp_t model(input req_t r);
    exp_t e;
    e.tag   = r.tag;
    e.tmask = r.tmask;
    e.data  = '0;
    for (int l = 0; l < NL; l++) begin
      if (r.tmask[l])
        e.data[32*l +: 32] = model_lane(r.sgn, r.rs1[32*l +: 32],
                                        r.rs2[32*l +: 32], r.rs3[32*l +: 32]);
    end
    return e;
  endfunction

  task automatic rand_req(output req_t r);
    r.sgn   = 1'($urandom_range(0, 1));
    r.tmask = NL'($urandom);
    r.tag   = TW'({$urandom, $urandom});
    for (int l = 0; l < NL; l++) begin
      r.rs1[32*l +: 32] = $urandom;
      r.rs2[32*l +: 32] = $urandom;
      r.rs3[32*l +: 32] = $urandom;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called just after a rising edge; returns just after the edge that
  // accepted the request, with its expected result already queued.
  // ---------------------------------------------------------------------------
  task automatic apply(input req_t r);
    execute_valid_i     = 1'b1;
    execute_op_signed_i = r.sgn;
    execute_tmask_i     = r.tmask;
    execute_tag_i       = r.tag;
    execute_rs1_data_i  = r.rs1;
    execute_rs2_data_i  = r.rs2;
    execute_rs3_data_i  = r.rs3;
  endtask

  task automatic wait_accept(input exp_t e);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (execute_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      sb_q.push_back(e);
    end
    check_bit("accept_within_budget", ok, 1'b1);
    execute_valid_i = 1'b0;
  endtask

  task automatic send(input req_t r, input exp_t e);
    apply(r);
    wait_accept(e);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 500 && sb_q.size() != 0; c++) @(negedge clk);
    check_bit(name, sb_q.size() == 0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    req_t r;
    req_t ra;
    req_t rb;
    req_t rc;
    exp_t e;
    exp_t ea;
    int   c0;
    int   base;

    vecs[0] = '{1'b0, 4'hF, 32'h01020304, 32'h04030201, 32'd10,       {4{32'd18}}};
    vecs[1] = '{1'b1, 4'hF, 32'h80808080, 32'h7F7F7F7F, 32'd0,        {4{32'd1020}}};
    vecs[2] = '{1'b0, 4'hF, 32'h80808080, 32'h7F7F7F7F, 32'd0,        {4{32'd4}}};
    vecs[3] = '{1'b0, 4'h5, 32'hFF00FF00, 32'h00FF00FF, 32'hFFFFFFFF, {32'd0, 32'd1019, 32'd0, 32'd1019}};
    vecs[4] = '{1'b1, 4'hF, 32'hFF00FF00, 32'h00FF00FF, 32'd0,        {4{32'd4}}};
    vecs[5] = '{1'b0, 4'hF, 32'h12345678, 32'h12345678, 32'h100,      {4{32'h100}}};
    vecs[6] = '{1'b1, 4'hA, 32'h7F800102, 32'h807FFE03, 32'd5,        {32'd519, 32'd0, 32'd519, 32'd0}};
    vecs[7] = '{1'b0, 4'hF, 32'h7F800102, 32'h807FFE03, 32'd5,        {4{32'd261}}};
    vecs[8] = '{1'b0, 4'h0, 32'hFFFFFFFF, 32'h00000000, 32'd1,        {4{32'd0}}};
    vecs[9] = '{1'b0, 4'hF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF00, {4{32'h2FC}}};

    reset_i             = 1'b0;
    execute_valid_i     = 1'b0;
    execute_op_signed_i = 1'b0;
    execute_tmask_i     = '0;
    execute_tag_i       = '0;
    execute_rs1_data_i  = '0;
    execute_rs2_data_i  = '0;
    execute_rs3_data_i  = '0;
    result_ready_i      = 1'b0;

    fork
      forever @(posedge clk) cyc++;
      forever begin
        @(posedge clk);
        #2;
        if (rand_rdy) result_ready_i = 1'($urandom_range(0, 1));
      end
      begin : monitor
        exp_t m;
        forever begin
          @(negedge clk);
          if (reset_i && result_valid_o && result_ready_i) begin
            check_bit("sb_entry_available", sb_q.size() > 0, 1'b1);
            if (sb_q.size() > 0) begin
              m = sb_q.pop_front();
              check_vec("result_data",  result_data_o, m.data);
              check_vec("result_tag",   128'(result_tag_o), 128'(m.tag));
              check_vec("result_tmask", 128'(result_tmask_o), 128'(m.tmask));
              out_cnt++;
            end
          end
        end
      end
    join_none

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_result_valid", result_valid_o, 1'b0);
    reset_i = 1'b1;
    @(negedge clk);
    check_bit("post_reset_ready", execute_ready_o, 1'b1);
    check_bit("post_reset_valid", result_valid_o, 1'b0);
    @(posedge clk);
    #1;

    // Directed table; row 0 also checks the two-cycle latency.
    result_ready_i = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      r.sgn   = vecs[i].sgn;
      r.tmask = vecs[i].tmask;
      r.tag   = TW'(44'h0A5_0000_0000 + 44'(i * 7 + 3));
      r.rs1   = {NL{vecs[i].rs1}};
      r.rs2   = {NL{vecs[i].rs2}};
      r.rs3   = {NL{vecs[i].rs3}};
      e.tag   = r.tag;
      e.tmask = r.tmask;
      e.data  = vecs[i].exp;
      send(r, e);
      if (i == 0) begin
        check_bit("latency_after_1_edge", result_valid_o, 1'b0);
        @(posedge clk);
        #1;
        check_bit("latency_after_2_edges", result_valid_o, 1'b1);
        check_vec("latency_data", result_data_o, vecs[0].exp);
      end
    end
    drain("table_drained");

    // Back-to-back streaming at full rate: 20 requests in 20 cycles.
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      rand_req(r);
      send(r, model(r));
    end
    check_vec("stream_cycles", 128'(cyc - c0), 128'(20));
    drain("stream_drained");

    // Backpressure: two accepts fill the pipe, the third stalls.
    result_ready_i = 1'b0;
    rand_req(ra);
    rand_req(rb);
    rand_req(rc);
    ea = model(ra);
    send(ra, ea);
    send(rb, model(rb));
    apply(rc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("bp_ready_low",   execute_ready_o, 1'b0);
      check_bit("bp_valid_held",  result_valid_o, 1'b1);
      check_vec("bp_data_held",   result_data_o, ea.data);
      check_vec("bp_tag_held",    128'(result_tag_o), 128'(ea.tag));
      check_vec("bp_tmask_held",  128'(result_tmask_o), 128'(ea.tmask));
    end
    @(posedge clk);
    #1;
    result_ready_i = 1'b1;
    wait_accept(model(rc));
    drain("bp_drained");

    // Random traffic with random backpressure.
    base     = out_cnt;
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      rand_req(r);
      send(r, model(r));
    end
    rand_rdy       = 1'b0;
    result_ready_i = 1'b1;
    drain("random_drained");
    check_vec("random_out_count", 128'(out_cnt - base), 128'(100));

    // Reset with two requests in flight: both must vanish.
    result_ready_i = 1'b0;
    rand_req(r);
    send(r, model(r));
    rand_req(r);
    send(r, model(r));
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    sb_q.delete();
    result_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("midrst_no_valid", result_valid_o, 1'b0);
      if (i == 0) check_bit("midrst_ready", execute_ready_o, 1'b1);
    end
    @(posedge clk);
    #1;
    rand_req(r);
    r.tmask = '1;
    e = model(r);
    send(r, e);
    check_bit("midrst_lat_1", result_valid_o, 1'b0);
    @(posedge clk);
    #1;
    check_bit("midrst_lat_2", result_valid_o, 1'b1);
    check_vec("midrst_data", result_data_o, e.data);
    drain("midrst_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
